// File: rtl/alu4_nibble_seq_if.sv
`default_nettype none
//==============================================================================
// Module      : alu4_nibble_seq_if
// Description : Bundle of the sequencer's command handshake, response
//               handshake and 4-bit ALU drive/return signals.
//               slave  : sequencer side (consumes commands, drives the ALU,
//                        produces responses).
//               master : environment side (command source, ALU, consumer).
//               rsp_ovf exists only when ALU4_SEQ_OVF_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
interface alu4_nibble_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int C_W = 4 * NIBBLES;

    // Command channel
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_mode;
    logic [1:0]     cmd_op;
    logic           cmd_cin;
    logic [C_W-1:0] cmd_a;
    logic [C_W-1:0] cmd_b;

    // ALU drive / return
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic           alu_cin;
    logic [1:0]     alu_op;
    logic           alu_mode;
    logic [3:0]     alu_f;
    logic           alu_cout;

    // Response channel
    logic           rsp_valid;
    logic           rsp_ready;
    logic [C_W-1:0] rsp_f;
    logic           rsp_cout;
`ifdef ALU4_SEQ_OVF_EN
    logic           rsp_ovf;
`endif

    modport slave (
`ifdef ALU4_SEQ_OVF_EN
        output rsp_ovf,
`endif
        input  cmd_valid, cmd_mode, cmd_op, cmd_cin, cmd_a, cmd_b,
        input  alu_f, alu_cout, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_cin, alu_op, alu_mode,
        output rsp_valid, rsp_f, rsp_cout
    );

    modport master (
`ifdef ALU4_SEQ_OVF_EN
        input  rsp_ovf,
`endif
        output cmd_valid, cmd_mode, cmd_op, cmd_cin, cmd_a, cmd_b,
        output alu_f, alu_cout, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_cin, alu_op, alu_mode,
        input  rsp_valid, rsp_f, rsp_cout
    );
endinterface
`default_nettype wire

// File: rtl/alu4_nibble_seq.sv
`default_nettype none
//==============================================================================
// Module      : alu4_nibble_seq
// Description : Nibble-serial sequencer for a 4-bit combinational ALU.
//               Accepts one W-bit command (W = 4*NIBBLES), issues one nibble
//               per cycle LSB first with the carry chained through a
//               register, and returns the assembled result.
//               Latency accept -> rsp_valid is NIBBLES+1 cycles.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - alu4_nibble_seq_if.slave (cmd_*, alu_*, rsp_*)
// Options     : ALU4_SEQ_OVF_EN - adds the rsp_ovf signed-overflow output.
// Revision    : 1.0 - initial release
//==============================================================================
module alu4_nibble_seq #(
    parameter int NIBBLES = 4               // legal range 1..16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu4_nibble_seq_if.slave    bus
);
    localparam int C_W     = 4 * NIBBLES;
    localparam int C_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NIBBLES - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_cmd_ready;
    logic               w_rsp_valid;
    logic               w_accept;
    logic               w_run;
    logic               w_last;

    // Effective operands and mapped ALU operation, formed at accept
    logic [C_W-1:0]     w_ae;
    logic [C_W-1:0]     w_be;
    logic [1:0]         w_op;

    // Remaining (not yet issued) nibbles, shifted down each RUN cycle
    logic [C_W-1:0]     r_ae_rem;
    logic [C_W-1:0]     r_be_rem;
    logic [C_IDX_W-1:0] r_idx;

    // ALU drive registers; r_alu_cin doubles as the chained carry register
    logic [3:0]         r_alu_a;
    logic [3:0]         r_alu_b;
    logic               r_alu_cin;
    logic [1:0]         r_alu_op;
    logic               r_alu_mode;
    logic               w_carry_nxt;

    logic [C_W-1:0]     r_f;
    logic               r_cout;

`ifdef ALU4_SEQ_OVF_EN
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_ovf;
`endif

    assign w_accept = (r_state == C_ST_IDLE) && bus.cmd_valid;
    assign w_run    = (r_state == C_ST_RUN);
    assign w_last   = w_run && (r_idx == C_LAST_IDX);

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: if (bus.cmd_valid) w_state_nxt = C_ST_RUN;
            C_ST_RUN:  if (r_idx == C_LAST_IDX) w_state_nxt = C_ST_DONE;
            C_ST_DONE: if (bus.rsp_ready) w_state_nxt = C_ST_IDLE;
            default:   w_state_nxt = C_ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            C_ST_IDLE: w_cmd_ready = 1'b1;
            C_ST_DONE: w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    //--------------------------------------------------------------------------
    // Operand / operation mapping. Subtractions become A + ~B + cin on the
    // ALU's add operation; increment/transfer uses op 00 with B forced to 0.
    //--------------------------------------------------------------------------
    always_comb begin
        w_ae = bus.cmd_a;
        w_be = bus.cmd_b;
        w_op = bus.cmd_op;
        if (bus.cmd_mode) begin
            case (bus.cmd_op)
                2'b00: begin
                    w_be = '0;
                    w_op = 2'b00;
                end
                2'b01: w_op = 2'b01;
                2'b10: begin
                    w_be = ~bus.cmd_b;
                    w_op = 2'b01;
                end
                default: begin
                    w_ae = bus.cmd_b;
                    w_be = ~bus.cmd_a;
                    w_op = 2'b01;
                end
            endcase
        end
    end

    // The ALU's Cout is undefined on a plain transfer (op 00 with no carry in)
    // and meaningless in logic mode, so it is masked to 0 in those cases.
    assign w_carry_nxt = (r_alu_mode && !((r_alu_op == 2'b00) && !r_alu_cin))
                         ? bus.alu_cout : 1'b0;

    //--------------------------------------------------------------------------
    // Datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ae_rem   <= '0;
            r_be_rem   <= '0;
            r_idx      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_cin  <= 1'b0;
            r_alu_op   <= '0;
            r_alu_mode <= 1'b0;
            r_f        <= '0;
            r_cout     <= 1'b0;
`ifdef ALU4_SEQ_OVF_EN
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_ovf      <= 1'b0;
`endif
        end else if (w_accept) begin
            // Nibble 0 is presented on the ALU in the first RUN cycle
            r_alu_a    <= w_ae[3:0];
            r_alu_b    <= w_be[3:0];
            r_ae_rem   <= w_ae >> 4;
            r_be_rem   <= w_be >> 4;
            r_alu_cin  <= bus.cmd_cin & bus.cmd_mode;
            r_alu_op   <= w_op;
            r_alu_mode <= bus.cmd_mode;
            r_idx      <= '0;
`ifdef ALU4_SEQ_OVF_EN
            r_sign_a   <= w_ae[C_W-1];
            r_sign_b   <= w_be[C_W-1];
`endif
        end else if (w_run) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (r_idx == C_IDX_W'(i)) begin
                    r_f[4*i +: 4] <= bus.alu_f;
                end
            end
            if (w_last) begin
                // ALU drive returns to all-zero outside RUN
                r_alu_a    <= '0;
                r_alu_b    <= '0;
                r_alu_cin  <= 1'b0;
                r_alu_op   <= '0;
                r_alu_mode <= 1'b0;
                r_cout     <= w_carry_nxt;
`ifdef ALU4_SEQ_OVF_EN
                r_ovf      <= r_alu_mode && (r_sign_a == r_sign_b)
                              && (bus.alu_f[3] != r_sign_a);
`endif
            end else begin
                r_alu_a    <= r_ae_rem[3:0];
                r_alu_b    <= r_be_rem[3:0];
                r_ae_rem   <= r_ae_rem >> 4;
                r_be_rem   <= r_be_rem >> 4;
                r_alu_cin  <= w_carry_nxt;
                r_idx      <= r_idx + 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Output drive (registers only)
    //--------------------------------------------------------------------------
    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_cin   = r_alu_cin;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_mode  = r_alu_mode;
    assign bus.rsp_f     = r_f;
    assign bus.rsp_cout  = r_cout;
`ifdef ALU4_SEQ_OVF_EN
    assign bus.rsp_ovf   = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu4_nibble_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu4_nibble_seq
// Description : Directed self-checking bench for alu4_nibble_seq (NIBBLES=4)
//               with a behavioural 4-bit ALU attached. The ALU model returns
//               Cout=1 wherever Cout is undefined or meaningless so that a
//               missing carry mask is visible.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu4_nibble_seq;
    localparam int NIB = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    alu4_nibble_seq_if #(.NIBBLES(NIB)) bus ();

    alu4_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: logic 00 AND, 01 OR, 10 XOR, 11 NOT A;
    // arith 00 A+cin, 01 A+B+cin.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        bus.alu_f    = '0;
        bus.alu_cout = 1'b1;
        if (!bus.alu_mode) begin
            case (bus.alu_op)
                2'b00:   bus.alu_f = bus.alu_a & bus.alu_b;
                2'b01:   bus.alu_f = bus.alu_a | bus.alu_b;
                2'b10:   bus.alu_f = bus.alu_a ^ bus.alu_b;
                default: bus.alu_f = ~bus.alu_a;
            endcase
        end else begin
            case (bus.alu_op)
                2'b00: begin
                    alu_sum      = {1'b0, bus.alu_a} + {4'b0, bus.alu_cin};
                    bus.alu_f    = alu_sum[3:0];
                    bus.alu_cout = bus.alu_cin ? alu_sum[4] : 1'b1;
                end
                2'b01: begin
                    alu_sum      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
                                   + {4'b0, bus.alu_cin};
                    bus.alu_f    = alu_sum[3:0];
                    bus.alu_cout = alu_sum[4];
                end
                default: begin
                    bus.alu_f    = '0;
                    bus.alu_cout = 1'b0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for the response, check it, then acknowledge.
    task automatic run_cmd(input string tag, input logic mode,
                           input logic [1:0] op, input logic cin,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_f, input logic exp_cout,
                           input logic exp_ovf,
                           output logic [15:0] seq, output logic cin_seen);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        bus.cmd_mode  = mode;
        bus.cmd_op    = op;
        bus.cmd_cin   = cin;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({tag, "_busy"}, bus.cmd_ready, 0);
        lat      = 1;
        seq      = '0;
        cin_seen = 1'b0;
        while (!bus.rsp_valid && lat < 40) begin
            seq      = {seq[11:0], bus.alu_a};
            cin_seen = cin_seen | bus.alu_cin;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, NIB + 1);
        check({tag, "_f"}, bus.rsp_f, exp_f);
        check({tag, "_cout"}, bus.rsp_cout, exp_cout);
`ifdef ALU4_SEQ_OVF_EN
        check({tag, "_ovf"}, bus.rsp_ovf, exp_ovf);
`endif
        check({tag, "_alu_idle"}, {bus.alu_a, bus.alu_b, bus.alu_cin,
                                   bus.alu_op, bus.alu_mode}, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_ack"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        if (exp_ovf === 1'bx) $display("note: unused ovf");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        logic        cin_seen;
        logic [15:0] held_f;
        int          hits;
        int          guard;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_cin   = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_f", bus.rsp_f, 0);
        check("rst_rsp_cout", bus.rsp_cout, 0);
        check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_cin,
                          bus.alu_op, bus.alu_mode}, 0);
`ifdef ALU4_SEQ_OVF_EN
        check("rst_rsp_ovf", bus.rsp_ovf, 0);
`endif
        rst_n = 1'b1;

        run_cmd("add", 1'b1, 2'b01, 1'b0, 16'h1234, 16'h0FFF,
                16'h2233, 1'b0, 1'b0, seq, cin_seen);
        check("add_alu_a_seq", seq, 16'h4321);

        run_cmd("sub", 1'b1, 2'b10, 1'b1, 16'h0005, 16'h0007,
                16'hFFFE, 1'b0, 1'b0, seq, cin_seen);
        run_cmd("inc_ffff", 1'b1, 2'b00, 1'b1, 16'hFFFF, 16'h0000,
                16'h0000, 1'b1, 1'b0, seq, cin_seen);
        run_cmd("inc_7fff", 1'b1, 2'b00, 1'b1, 16'h7FFF, 16'h0000,
                16'h8000, 1'b0, 1'b1, seq, cin_seen);
        run_cmd("xfer", 1'b1, 2'b00, 1'b0, 16'hABCD, 16'h1111,
                16'hABCD, 1'b0, 1'b0, seq, cin_seen);
        run_cmd("and", 1'b0, 2'b00, 1'b1, 16'hF0F0, 16'h3C3C,
                16'h3030, 1'b0, 1'b0, seq, cin_seen);
        check("and_alu_cin", cin_seen, 0);
        run_cmd("rsub", 1'b1, 2'b11, 1'b1, 16'h0001, 16'h0010,
                16'h000F, 1'b1, 1'b0, seq, cin_seen);

        // Response held off for 3 cycles with a stray command in between
        @(negedge clk);
        bus.cmd_mode  = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_cin   = 1'b0;
        bus.cmd_a     = 16'h0001;
        bus.cmd_b     = 16'h0002;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        guard = 0;
        while (!bus.rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("hold_valid", bus.rsp_valid, 1);
        held_f = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_f", bus.rsp_f, held_f);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            bus.cmd_a     = 16'h5555;
            bus.cmd_valid = (i == 0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("hold_ack", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) hits++;
        end
        check("hold_not_queued", hits, 0);
        check("hold_f_kept", bus.rsp_f, held_f);

        // Reset in the middle of RUN drops the command
        @(negedge clk);
        bus.cmd_a     = 16'h1111;
        bus.cmd_b     = 16'h2222;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_alu", {bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
        rst_n = 1'b1;
        check("mrst_cmd_ready", bus.cmd_ready, 1);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) hits++;
        end
        check("mrst_no_rsp", hits, 0);
        run_cmd("post_rst_add", 1'b1, 2'b01, 1'b0, 16'h00FF, 16'h0001,
                16'h0100, 1'b0, 1'b0, seq, cin_seen);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu4_nibble_seq.md
# alu4_nibble_seq

Nibble-serial arithmetic/logic sequencer that drives a 4-bit combinational ALU (A, B, Cin, Operation, Mode -> F, Cout) to execute wide operations. It accepts one wide command over a valid/ready handshake and issues one nibble per cycle to the ALU, LSB first. It chains the carry through a register and returns the assembled result over a second valid/ready handshake. It sits between a command source and the existing ALU instance.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_mode  in  1  0 = logic, 1 = arithmetic
- cmd_op  in  2  operation select (see Operation)
- cmd_cin  in  1  carry into nibble 0 (arithmetic only)
- cmd_a, cmd_b  in  W  operands
- alu_a, alu_b  out  4  nibble operands to ALU
- alu_cin  out  1  carry to ALU
- alu_op  out  2  Operation to ALU
- alu_mode  out  1  Mode to ALU
- alu_f  in  4  ALU result
- alu_cout  in  1  ALU carry out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_f  out  W  result
- rsp_cout  out  1  carry out of top nibble
- rsp_ovf  out  1  signed overflow (only with ALU4_SEQ_OVF_EN)

## Operation
- FSM states: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, set idx=0 and go to RUN.
  - RUN: lasts exactly NIBBLES cycles, idx 0..NIBBLES-1, then go to DONE.
  - DONE: rsp_valid=1. On rsp_ready, go to IDLE.
- Effective operands are formed at accept (Ae, Be, both W bits), with the ALU op mapping:
  - mode 0 (logic): Ae=A, Be=B; alu_op=cmd_op unchanged, alu_mode=0; carry forced to 0.
  - mode 1, op 00 (pass/increment): Ae=A, Be=0; alu_op=00.
  - mode 1, op 01 (add): Ae=A, Be=B; alu_op=01.
  - mode 1, op 10 (A minus B): Ae=A, Be=~B; alu_op=01. Two's-complement subtract needs cmd_cin=1.
  - mode 1, op 11 (B minus A): Ae=B, Be=~A; alu_op=01.
- Carry register carry_q:
  - Loaded at accept with cmd_cin & cmd_mode.
  - Each RUN cycle: alu_cin = carry_q, alu_a = Ae[4*idx+:4], alu_b = Be[4*idx+:4].
- Capture at each RUN edge:
  - rsp_f[4*idx+:4] <= alu_f.
  - carry_q <= alu_cout when mode=1 and not (alu_op=00 and carry_q=0); otherwise carry_q <= 0. This masks the ALU's undefined Cout on plain transfer.
- rsp_cout = carry_q after the last nibble; always 0 in logic mode.
- alu_* are driven only from registers. In IDLE and DONE, alu_a, alu_b, alu_cin, alu_op and alu_mode are all 0.
- There is no combinational path from cmd_* or alu_f/alu_cout to any output.

## Timing
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_ovf=0, all alu_*=0, carry_q=0.
- Accept at edge T (cmd_valid & cmd_ready). RUN occupies cycles T+1..T+NIBBLES. rsp_valid rises in cycle T+NIBBLES+1, i.e. latency NIBBLES+1 cycles.
- rsp_f, rsp_cout and rsp_ovf are stable while rsp_valid=1 and rsp_ready=0.
- If rsp_ready is already high when rsp_valid rises, the handshake completes at that edge and cmd_ready=1 the next cycle.
- Maximum throughput is one command per NIBBLES+2 cycles.
- cmd_ready=0 in RUN and DONE. cmd_valid in those states is ignored and not queued.
- rsp_f holds its value until the next command's nibbles overwrite it.
- Reset asserted mid-operation: return to IDLE immediately; the in-flight command is dropped and no response is issued.
- NIBBLES=1: RUN lasts one cycle.

## Configuration
- ALU4_SEQ_OVF_EN defined: the rsp_ovf port exists.
  - Captured on the last RUN edge as (Ae[W-1]==Be[W-1]) && (alu_f[3]!=Ae[W-1]) when mode=1.
  - Always 0 in logic mode.
- ALU4_SEQ_OVF_EN undefined: the rsp_ovf port and its register are absent; all other behaviour is identical.

## Test plan
- NIBBLES=4, add 0x1234+0x0FFF, cin 0 -> rsp_f=0x2233, rsp_cout=0; rsp_valid exactly 5 cycles after accept; alu_a sequence 4,3,2,1.
- Subtract (op 10) 0x0005-0x0007, cin 1 -> rsp_f=0xFFFE, rsp_cout=0, rsp_ovf=0.
- Increment (op 00, cin 1):
  - 0xFFFF -> rsp_f=0x0000, rsp_cout=1, rsp_ovf=0.
  - 0x7FFF -> rsp_f=0x8000, rsp_ovf=1.
  - Transfer (cin 0) of 0xABCD -> 0xABCD, cout 0.
- Logic AND 0xF0F0 & 0x3C3C, mode 0 -> rsp_f=0x3030, rsp_cout=0; alu_cin=0 in every RUN cycle. Reverse subtract (op 11) A=0x0001, B=0x0010, cin 1 -> rsp_f=0x000F, rsp_cout=1.
- Hold rsp_ready low for 3 cycles -> rsp_f stable, cmd_ready=0, and a cmd_valid pulse in that window is ignored.
- Assert rst_n low after the second RUN cycle -> rsp_valid never rises; cmd_ready=1 once reset is released; a subsequent add completes correctly.
